// File: rtl/alu_pkg.sv
// Shared ALU definitions: datapath width, multiplier FSM states and the
// two's-complement magnitude helper that the divider also uses.
package alu_pkg;

  localparam int ALU_WIDTH = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    SIGN = 2'd2
  } mul_state_t;

  // Magnitude of a two's-complement value; -2^63 maps to 2^63 as unsigned.
  function automatic logic [ALU_WIDTH-1:0] abs64(input logic [ALU_WIDTH-1:0] x);
    return x[ALU_WIDTH-1] ? ((~x) + ALU_WIDTH'(1)) : x;
  endfunction

endpackage

// File: rtl/seq_multiplier_if.sv
// Start/done handshake and operand/result bus between the ALU and the
// sequential multiplier.
interface seq_multiplier_if #(parameter int WIDTH = alu_pkg::ALU_WIDTH) ();
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] prod_lo;
  logic [WIDTH-1:0] prod_hi;
  logic             ovf;
  logic             busy;
  logic             done;

  modport master (output start, a, b,
                  input  prod_lo, prod_hi, ovf, busy, done);
  modport slave  (input  start, a, b,
                  output prod_lo, prod_hi, ovf, busy, done);
endinterface

// File: rtl/seq_multiplier.sv
// Signed WIDTHxWIDTH shift-add multiplier, one multiplier bit per clock.
// Operates on magnitudes and applies the sign in a final 2*WIDTH-bit step.
// Optional: MUL_EARLY_TERM_EN ends RUN as soon as the remaining multiplier
// bits are zero and realigns the accumulator with one barrel shift.
//
//  state | meaning
//  IDLE  | waiting for start; first IDLE cycle after SIGN still reports busy
//  RUN   | add |a| into acc_hi when multiplier lsb set, then shift right
//  SIGN  | apply sign, register product/ovf, pulse done
module seq_multiplier
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic              clk,
  input  logic              rst_n,
  seq_multiplier_if.slave   mul_if
);

  localparam int IW = $clog2(WIDTH + 1);
  localparam logic [2*WIDTH-1:0] ONE = (2*WIDTH)'(1);

  mul_state_t         state_q;
  logic [WIDTH-1:0]   mcand_q;
  logic [WIDTH-1:0]   mult_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [IW-1:0]      iter_q;
  logic               neg_q;
  logic [WIDTH-1:0]   prod_lo_q;
  logic [WIDTH-1:0]   prod_hi_q;
  logic               ovf_q;
  logic               busy_q;
  logic               done_q;

  logic [WIDTH:0]     sum_d;
  logic [2*WIDTH-1:0] acc_d;
  logic [WIDTH-1:0]   mult_d;
  logic               run_last_d;
  logic [2*WIDTH-1:0] acc_aligned_d;
  logic [2*WIDTH-1:0] prod_d;
  logic               ovf_d;

  // Single 65-bit adder, the shifted accumulator and the sign-fixed product.
  always_comb begin
    sum_d  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (mult_q[0] ? {1'b0, mcand_q} : '0);
    acc_d  = {sum_d, acc_q[WIDTH-1:1]};
    mult_d = mult_q >> 1;
`ifdef MUL_EARLY_TERM_EN
    run_last_d    = (mult_d == '0);
    acc_aligned_d = acc_q >> (IW'(WIDTH) - iter_q);
`else
    run_last_d    = (iter_q == IW'(WIDTH - 1));
    acc_aligned_d = acc_q;
`endif
    prod_d = neg_q ? ((~acc_aligned_d) + ONE) : acc_aligned_d;
    // Representable iff the top WIDTH+1 bits are a pure sign extension.
    ovf_d  = !((&prod_d[2*WIDTH-1:WIDTH-1]) || !(|prod_d[2*WIDTH-1:WIDTH-1]));
  end

  // Control FSM with registered datapath and outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      mcand_q   <= '0;
      mult_q    <= '0;
      acc_q     <= '0;
      iter_q    <= '0;
      neg_q     <= 1'b0;
      prod_lo_q <= '0;
      prod_hi_q <= '0;
      ovf_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          busy_q <= 1'b0;
          if (mul_if.start && !busy_q) begin
            mcand_q <= abs64(mul_if.a);
            mult_q  <= abs64(mul_if.b);
            neg_q   <= mul_if.a[WIDTH-1] ^ mul_if.b[WIDTH-1];
            acc_q   <= '0;
            iter_q  <= '0;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end
        end
        RUN: begin
          acc_q  <= acc_d;
          mult_q <= mult_d;
          iter_q <= iter_q + IW'(1);
          if (run_last_d) state_q <= SIGN;
        end
        SIGN: begin
          prod_hi_q <= prod_d[2*WIDTH-1:WIDTH];
          prod_lo_q <= prod_d[WIDTH-1:0];
          ovf_q     <= ovf_d;
          done_q    <= 1'b1;
          state_q   <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mul_if.prod_lo = prod_lo_q;
  assign mul_if.prod_hi = prod_hi_q;
  assign mul_if.ovf     = ovf_q;
  assign mul_if.busy    = busy_q;
  assign mul_if.done    = done_q;

endmodule
